dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-ported data_memory. Port 0 is the CPU
//  load/store path, port 1 the debug/program-loader path. Grants one port at a time (round-robin),
//  drives the memory for exactly one clock, then returns read data and a one-cycle ack.
//  Also rejects misaligned and out-of-range word accesses before they reach the memory.
// PARAMETERS
//  MEM_BYTES  256  byte capacity of the attached data memory; legal word addr <= MEM_BYTES-4
//  ADDR_W     32   width of requester and memory address buses
// PORTS
//  clk          in   1       system clock; all state updates on posedge
//  rst          in   1       asynchronous, active-high reset
//  req0/req1    in   1       access request; held high, address/data stable, until ack seen
//  wr0/wr1      in   1       1 = word write, 0 = word read
//  addr0/addr1  in   ADDR_W  byte address of word (big-endian, byte at addr is bits 31:24)
//  wdata0/1     in   32      write data
//  ack0/ack1    out  1       one-cycle completion pulse for the corresponding port
//  err0/err1    out  1       valid with ack: access rejected (misaligned or out of range)
//  rdata        out  32      read data, valid during ack of a read; shared by both ports
//  mem_addr     out  ADDR_W  to data_memory addr
//  mem_din      out  32      to data_memory Din
//  mem_wrt      out  1       to data_memory memWrt
//  mem_dout     in   32      from data_memory Dout (memory samples/updates on negedge clk)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ack*=0, err*=0, rdata=0, mem_wrt=0, rr_last=1
//   (port 0 wins first tie), latched request regs=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; RESP always returns to IDLE (no back-to-back).
//   IDLE:  at posedge, if any req: pick winner, latch sel/wr/addr/wdata/err, rr_last<=sel,
//          go ACCESS. No req: stay IDLE.
//   ACCESS: mem_addr=latched addr, mem_din=latched wdata, mem_wrt=latched wr & ~latched err
//          (combinational from latched regs, stable across the whole cycle so the memory's
//          negedge read/write sees clean values). At posedge: rdata<=mem_dout if read & ~err,
//          else rdata holds; ack[sel]<=1, err[sel]<=latched err; go RESP.
//   RESP:  ack/err asserted this cycle only; mem_wrt=0. At posedge: ack*,err*<=0; go IDLE.
//  Latency: req high before edge E0 (state IDLE) -> ack high in cycle after E1 -> 2 cycles;
//   throughput 1 access / 3 cycles. Requester must drop or re-present req by edge E2.
//  Arbitration: single req -> that port. Both -> port != rr_last. rr_last updates only on grant.
//  err = (addr[1:0]!=0) | (addr > MEM_BYTES-4); errored access never asserts mem_wrt.
//  mem_wrt=0 in IDLE and RESP; mem_addr/mem_din hold latched values outside ACCESS.
//  Req dropped by requester mid-access: access still completes and acks (no cancel).
//  Reset during ACCESS: mem_wrt drops immediately; write not performed if reset asserts before
//   the negedge of that cycle, otherwise already committed. No ack is ever issued for it.
//  Never more than one ack high in any cycle.
// STRUCTURE
//  Shared header (dmem_defs.vh): FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2),
//   port index constants P_CPU=0, P_DBG=1; reused by the memory top-level and bench.
//  Sub-module rr_arb2: pure 2-way round-robin picker (req0, req1, rr_last -> sel, any).
//  Remainder (FSM, request latches, error check, mem drive) stays in dmem_arbiter.
// TESTING (bench instantiates dmem_arbiter + data_memory, MEM_BYTES=256)
//  1. Reset then port0 write addr=0x10 data=0xDEADBEEF, then read 0x10 -> ack0 two cycles after
//     req each time, err0=0, rdata=0xDEADBEEF, ack1 never asserted.
//  2. req0 and req1 raised same cycle after reset (reads of 0x00/0x04) -> port0 acked first,
//     port1 acked 3 cycles later; repeat with both held -> grants alternate 1,0,1,0.
//  3. Port1 write addr=0x12 -> ack1 & err1 =1, mem_wrt never high; read 0x10 still returns
//     prior contents. Same for addr=0xFD and 0x100 (out of range); addr=0xFC accepted.
//  4. Byte order: write 0x11223344 at 0x20, read 0x20 -> 0x11223344; memory byte[0x20]=0x11.
//  5. Assert rst during ACCESS of a write to 0x30 (before negedge) -> state IDLE, no ack,
//     mem_wrt=0 instantly; subsequent read 0x30 returns old value.
//  6. Port0 drops req during ACCESS -> ack0 still pulses once; no second access issued.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and port indices.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic sel,
    output logic any
);

    always_comb begin
        any = req0 | req1;
        sel = (req0 & req1) ? ~rr_last : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing CPU and debug word accesses onto the single-ported data memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wrt,
    input  logic [31:0]       mem_dout
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t            r_state;
    logic              r_sel;
    logic              r_wr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_rr_last;
    logic [31:0]       r_rdata;
    logic              r_ack0, r_ack1, r_err0, r_err1;

    logic              w_sel, w_any, w_wr, w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    rr_arb2 u_rr_arb2 (
        .req0    (req0),
        .req1    (req1),
        .rr_last (r_rr_last),
        .sel     (w_sel),
        .any     (w_any)
    );

    always_comb begin
        w_addr  = w_sel ? addr1  : addr0;
        w_wdata = w_sel ? wdata1 : wdata0;
        w_wr    = w_sel ? wr1    : wr0;
        w_err   = (w_addr[1:0] != 2'b00) || (w_addr > LAST_WORD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= 1'b0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rr_last <= 1'b1;
            r_rdata   <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel     <= w_sel;
                        r_wr      <= w_wr;
                        r_err     <= w_err;
                        r_addr    <= w_addr;
                        r_wdata   <= w_wdata;
                        r_rr_last <= w_sel;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Memory has already produced Dout on the preceding negedge.
                    if (!r_wr && !r_err)
                        r_rdata <= mem_dout;
                    r_ack0  <= (r_sel == P_CPU);
                    r_ack1  <= (r_sel == P_DBG);
                    r_err0  <= (r_sel == P_CPU) & r_err;
                    r_err1  <= (r_sel == P_DBG) & r_err;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write strobe is decoded from state so an async reset removes it within the cycle.
    always_comb begin
        mem_addr = r_addr;
        mem_din  = r_wdata;
        mem_wrt  = (r_state == ST_ACCESS) & r_wr & ~r_err;
        ack0     = r_ack0;
        ack1     = r_ack1;
        err0     = r_err0;
        err1     = r_err1;
        rdata    = r_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-clocked big-endian byte memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;
    logic        mem_wrt;

    int n_pass  = 0;
    int n_total = 0;
    int wrt_cnt = 0;
    int both_ack_cnt = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wrt(mem_wrt), .mem_dout(mem_dout)
    );

    // Data memory model: reads and writes on negedge, byte at addr is bits 31:24.
    initial begin
        logic [7:0]  idx;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = 32'h01020304;
        {mem[8'h04], mem[8'h05], mem[8'h06], mem[8'h07]} = 32'h05060708;
        {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]} = 32'hA5A5A5A5;
        mem_dout = 32'h0;
        forever begin
            @(negedge clk);
            idx = mem_addr[7:0];
            rd  = {mem[idx], mem[idx + 8'd1], mem[idx + 8'd2], mem[idx + 8'd3]};
            if (mem_wrt)
                {mem[idx], mem[idx + 8'd1], mem[idx + 8'd2], mem[idx + 8'd3]} = mem_din;
            mem_dout = rd;
        end
    end

    always @(negedge clk) begin
        if (mem_wrt) wrt_cnt++;
        if (ack0 && ack1) both_ack_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one access; assumes the FSM is IDLE and time is just after a posedge.
    task automatic do_access(input string tag, input logic p, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic e, input logic chk_rd, input logic [31:0] erd);
        int   cyc = 0;
        int   wbase;
        logic got = 1'b0;
        logic other = 1'b0;
        logic eseen = 1'b0;
        wbase = wrt_cnt;
        if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (p ? ack0 : ack1) other = 1'b1;
            if (p ? ack1 : ack0) begin got = 1'b1; eseen = p ? err1 : err0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk({tag, " latency"}, cyc, 2);
        chk({tag, " err"}, {31'b0, eseen}, {31'b0, e});
        chk({tag, " other_ack"}, {31'b0, other}, 0);
        if (chk_rd) chk({tag, " rdata"}, rdata, erd);
        @(posedge clk); #1;
        chk({tag, " ack_pulse"}, {30'b0, ack0, ack1}, 0);
        chk({tag, " wrt_count"}, wrt_cnt - wbase, (w && !e) ? 1 : 0);
    endtask

    typedef struct {
        string       tag;
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int a0, a1, n;
        int seq[4];
        logic [31:0] rd0, rd1, rdv;

        vecs[0]  = '{"w10",    1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{"r10",    1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{"w12mis", 1'b1, 1'b1, 32'h12,  32'h55555555, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{"r10b",   1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{"wFD",    1'b1, 1'b1, 32'hFD,  32'h66666666, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{"w100",   1'b1, 1'b1, 32'h100, 32'h77777777, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{"r10c",   1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[7]  = '{"wFC",    1'b1, 1'b1, 32'hFC,  32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{"rFC",    1'b1, 1'b0, 32'hFC,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
        vecs[9]  = '{"r101",   1'b1, 1'b0, 32'h101, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{"w20",    1'b0, 1'b1, 32'h20,  32'h11223344, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{"r20",    1'b0, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h11223344};
        vecs[12] = '{"r0",     1'b1, 1'b0, 32'h00,  32'h0,        1'b0, 1'b1, 32'h01020304};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #1;
        chk("reset acks", {28'b0, ack0, ack1, err0, err1}, 0);
        chk("reset rdata", rdata, 0);
        chk("reset mem_wrt", {31'b0, mem_wrt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            do_access(vecs[i].tag, vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].chk_rd, vecs[i].exp_rd);
        chk("byte order mem[0x20]", {24'b0, mem[8'h20]}, 32'h11);
        chk("mis write untouched mem[0x10]", {24'b0, mem[8'h13]}, 32'hEF);

        // Simultaneous requests straight after reset: port 0 first, port 1 three cycles later.
        rst = 1'b1; #1; rst = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h00;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h04;
        a0 = 0; a1 = 0; rd0 = '0; rd1 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ack0 && a0 == 0) begin a0 = c; rd0 = rdata; req0 = 1'b0; end
            if (ack1 && a1 == 0) begin a1 = c; rd1 = rdata; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie ack0 cycle", a0, 2);
        chk("tie ack1 cycle", a1, 5);
        chk("tie rdata0", rd0, 32'h01020304);
        chk("tie rdata1", rd1, 32'h05060708);

        // A solo port-0 grant leaves port 1 next in line for a sustained tie.
        do_access("solo0", 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b1, 32'h01020304);
        req0 = 1'b1; req1 = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) begin
                if (n < 4) seq[n] = ack1 ? 1 : 0;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("held ack count", n, 7);
        chk("alt grant 0", seq[0], 1);
        chk("alt grant 1", seq[1], 0);
        chk("alt grant 2", seq[2], 1);
        chk("alt grant 3", seq[3], 0);
        repeat (3) @(posedge clk);
        #1;

        // Reset asserted inside ACCESS, before the memory's negedge.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h12345678;
        @(posedge clk); #1;
        chk("access mem_wrt", {31'b0, mem_wrt}, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst mem_wrt", {31'b0, mem_wrt}, 0);
        chk("rst acks", {30'b0, ack0, ack1}, 0);
        req0 = 1'b0; wr0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ack0 || ack1) n++;
        end
        chk("rst no ack", n, 0);
        do_access("r30", 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);

        // Requester withdraws during ACCESS; the access still completes exactly once.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h04;
        @(posedge clk); #1;
        req0 = 1'b0;
        n = 0; rdv = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack0) begin n++; rdv = rdata; end
        end
        chk("drop ack0 count", n, 1);
        chk("drop rdata", rdv, 32'h05060708);

        chk("never two acks", both_ack_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
